// File: rtl/mole_hit_detect.sv
// Per-mole whack-button front end: 2-FF sync, per-channel debounce, press edge detect,
// hit/miss qualification against the mole-up mask. Optional miss output: MISS_DETECT_EN.
module mole_hit_detect #(
  parameter int unsigned N_MOLES         = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_active,
  input  logic [N_MOLES-1:0] btn_raw,
  input  logic [N_MOLES-1:0] mole_up,
  output logic [N_MOLES-1:0] btn_db,
  output logic [N_MOLES-1:0] hit_pulse,
  output logic               hit_pulse_any,
  output logic               miss_pulse_any
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_MOLES-1:0] s1_q, s2_q;
  logic [N_MOLES-1:0] db_q, db_d;
  logic [N_MOLES-1:0] prev_q;
  logic [N_MOLES-1:0] lock_q, lock_d;
  logic [N_MOLES-1:0] hit_q, hit_d;
  logic [N_MOLES-1:0] press;
  logic [CNT_W-1:0]   cnt_q [N_MOLES];
  logic [CNT_W-1:0]   cnt_d [N_MOLES];
  logic               hit_any_q, hit_any_d;

  // Counter only advances while the synchronised level disagrees with the accepted one,
  // so any bounce back to the accepted level restarts it and it never wraps.
  always_comb begin
    db_d = db_q;
    for (int unsigned i = 0; i < N_MOLES; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    press     = db_q & ~prev_q;
    hit_d     = press & mole_up & {N_MOLES{game_active}} & ~lock_q;
    hit_any_d = |hit_d;
    // A lock survives only while its mole stays up during an active round.
    lock_d    = (lock_q | hit_d) & mole_up & {N_MOLES{game_active}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      db_q      <= '0;
      prev_q    <= '0;
      lock_q    <= '0;
      hit_q     <= '0;
      hit_any_q <= 1'b0;
      for (int unsigned i = 0; i < N_MOLES; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q      <= btn_raw;
      s2_q      <= s1_q;
      db_q      <= db_d;
      prev_q    <= db_q;
      lock_q    <= lock_d;
      hit_q     <= hit_d;
      hit_any_q <= hit_any_d;
      for (int unsigned i = 0; i < N_MOLES; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef MISS_DETECT_EN
  logic miss_q, miss_d;

  always_comb begin
    miss_d = game_active & (|(press & ~mole_up & ~lock_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_q <= 1'b0;
    end else begin
      miss_q <= miss_d;
    end
  end

  assign miss_pulse_any = miss_q;
`else
  assign miss_pulse_any = 1'b0;
`endif

  assign btn_db        = db_q;
  assign hit_pulse     = hit_q;
  assign hit_pulse_any = hit_any_q;

endmodule

// File: tb/tb_mole_hit_detect.sv
// Self-checking bench for mole_hit_detect (N_MOLES=4, DEBOUNCE_CYCLES=4): window-based
// behavioural model compared every cycle, plus hand-computed literal checks per scenario.
module tb_mole_hit_detect;
  localparam int N = 4;
  localparam int D = 4;
`ifdef MISS_DETECT_EN
  localparam int EXP_MISS = 1;
`else
  localparam int EXP_MISS = 0;
`endif

  logic         clk, rst, game_active;
  logic [N-1:0] btn_raw, mole_up;
  logic [N-1:0] btn_db, hit_pulse;
  logic         hit_pulse_any, miss_pulse_any;

  mole_hit_detect #(.N_MOLES(N), .DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .game_active(game_active), .btn_raw(btn_raw), .mole_up(mole_up),
    .btn_db(btn_db), .hit_pulse(hit_pulse), .hit_pulse_any(hit_pulse_any),
    .miss_pulse_any(miss_pulse_any)
  );

  int checks = 0, errors = 0, cyc = 0;
  int d_hits = 0, d_misses = 0, m_hits = 0, m_misses = 0;
  bit cmp_en = 0;

  // Model state: raw samples per edge, accepted level, previous level, one-hit-per-appearance flags.
  logic [N-1:0] hist [0:D];
  logic [N-1:0] m_db, m_prev, m_lock, m_hit, m_pr;
  logic         m_any, m_miss, all_diff;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int ch, input int hold, input int rel);
    btn_raw[ch] = 1'b1;
    cyc_n(hold);
    btn_raw[ch] = 1'b0;
    cyc_n(rel);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    m_db = '0; m_prev = '0; m_lock = '0; m_hit = '0; m_any = 0; m_miss = 0;
    for (int k = 0; k <= D; k++) hist[k] = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_db = '0; m_prev = '0; m_lock = '0; m_hit = '0; m_any = 0; m_miss = 0;
        for (int k = 0; k <= D; k++) hist[k] = '0;
      end else begin
        m_pr   = m_db & ~m_prev;
        m_hit  = m_pr & mole_up & {N{game_active}} & ~m_lock;
        m_any  = |m_hit;
        m_miss = (EXP_MISS != 0) && game_active && (|(m_pr & ~mole_up & ~m_lock));
        m_lock = (m_lock | m_hit) & mole_up & {N{game_active}};
        if (m_any) m_hits++;
        if (m_miss) m_misses++;
        m_prev = m_db;
        // Accept a new level once the synchronised input has disagreed for D consecutive edges.
        for (int i = 0; i < N; i++) begin
          all_diff = 1'b1;
          for (int j = 1; j <= D; j++) if (hist[j][i] == m_db[i]) all_diff = 1'b0;
          if (all_diff) m_db[i] = ~m_db[i];
        end
        for (int k = D; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = btn_raw;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("btn_db", 32'(btn_db), 32'(m_db));
      chk("hit_pulse", 32'(hit_pulse), 32'(m_hit));
      chk("hit_pulse_any", 32'(hit_pulse_any), 32'(m_any));
      chk("miss_pulse_any", 32'(miss_pulse_any), 32'(m_miss));
      if (hit_pulse_any) d_hits++;
      if (miss_pulse_any) d_misses++;
    end
  end

  initial begin
    int t, h0, mi0, mh0;
    rst = 1'b1; game_active = 1'b0; btn_raw = '0; mole_up = '0;
    cyc_n(2);
    chk("reset_btn_db", 32'(btn_db), 32'h0);
    chk("reset_hit", 32'(hit_pulse), 32'h0);
    chk("reset_hit_any", 32'(hit_pulse_any), 32'h0);
    chk("reset_miss_any", 32'(miss_pulse_any), 32'h0);
    cmp_en = 1;
    rst = 1'b0;
    cyc_n(2);

    // Clean press on mole 1
    mole_up = 4'b0010; game_active = 1'b1;
    cyc_n(1);
    h0 = d_hits; mh0 = m_hits;
    btn_raw[1] = 1'b1; t = cyc + 1;
    cyc_n(5);
    chk("clean_db_t4", 32'(btn_db[1]), 32'h0);
    cyc_n(1);
    chk("clean_db_t5", 32'(btn_db[1]), 32'h1);
    chk("clean_edge_t5", 32'(cyc), 32'(t + 5));
    cyc_n(1);
    chk("clean_hit_t6", 32'(hit_pulse), 32'b0010);
    chk("clean_any_t6", 32'(hit_pulse_any), 32'h1);
    cyc_n(1);
    chk("clean_any_t7", 32'(hit_pulse_any), 32'h0);
    cyc_n(10);
    chk("clean_one_hit", 32'(d_hits - h0), 32'h1);
    chk("model_clean_one_hit", 32'(m_hits - mh0), 32'h1);
    btn_raw[1] = 1'b0;
    cyc_n(8);

    // Bounce on mole 1 after a fresh appearance
    mole_up = 4'b0000; cyc_n(1); mole_up = 4'b0010; cyc_n(1);
    h0 = d_hits;
    for (int k = 0; k < 4; k++) begin
      btn_raw[1] = ~btn_raw[1];
      cyc_n(2);
    end
    chk("bounce_no_accept", 32'(btn_db[1]), 32'h0);
    press(1, 10, 8);
    chk("bounce_one_hit", 32'(d_hits - h0), 32'h1);

    // Double whack on mole 2
    mole_up = 4'b0100; cyc_n(1);
    h0 = d_hits; mi0 = d_misses; mh0 = m_hits;
    press(2, 8, 8);
    press(2, 8, 8);
    mole_up = 4'b0000; cyc_n(2); mole_up = 4'b0100; cyc_n(1);
    press(2, 8, 8);
    chk("double_hits", 32'(d_hits - h0), 32'h2);
    chk("model_double_hits", 32'(m_hits - mh0), 32'h2);
    chk("double_no_miss", 32'(d_misses - mi0), 32'h0);

    // Simultaneous hits on 0 and 3
    mole_up = 4'b0000; cyc_n(1); mole_up = 4'b1111; cyc_n(1);
    h0 = d_hits;
    btn_raw = 4'b1001;
    cyc_n(7);
    chk("simul_hit", 32'(hit_pulse), 32'b1001);
    chk("simul_any", 32'(hit_pulse_any), 32'h1);
    cyc_n(1);
    chk("simul_any_off", 32'(hit_pulse_any), 32'h0);
    btn_raw = '0;
    cyc_n(8);
    chk("simul_single_pulse", 32'(d_hits - h0), 32'h1);

    // Press on a lowered mole
    mole_up = 4'b0000; cyc_n(1);
    h0 = d_hits; mi0 = d_misses;
    press(0, 8, 8);
    chk("miss_count", 32'(d_misses - mi0), 32'(EXP_MISS));
    chk("miss_no_hit", 32'(d_hits - h0), 32'h0);

    // Round inactive
    game_active = 1'b0; mole_up = 4'b1111; cyc_n(1);
    h0 = d_hits; mi0 = d_misses;
    press(2, 8, 8);
    chk("inactive_no_hit", 32'(d_hits - h0), 32'h0);
    chk("inactive_no_miss", 32'(d_misses - mi0), 32'h0);

    // Async reset with an accepted level
    game_active = 1'b1; cyc_n(1);
    btn_raw[3] = 1'b1;
    cyc_n(8);
    chk("pre_rst_db", 32'(btn_db[3]), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_db", 32'(btn_db), 32'h0);
    chk("rst_async_hit", 32'(hit_pulse), 32'h0);
    btn_raw = '0;
    cyc_n(2);
    rst = 1'b0;
    cyc_n(2);

    // Reset mid-debounce discards the count
    h0 = d_hits;
    btn_raw[1] = 1'b1;
    cyc_n(3);
    #2 rst = 1'b1;
    btn_raw = '0;
    cyc_n(2);
    rst = 1'b0;
    cyc_n(12);
    chk("midcount_no_hit", 32'(d_hits - h0), 32'h0);
    chk("midcount_db", 32'(btn_db), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
